mem_bus_arbiter: RTL

Arbitrates the single memory bus between the instruction cache and the data cache. Forwards at most one command per cycle to `mem` and returns the accept tag to the requester that issued it. Records which requester owns each outstanding load tag, then steers returning data to that owner. Sits between `icache`/`dcache` and `mem`.

---
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants icache/dcache onto one memory bus and steers returning load
// data to the owner of each tag. Define MEM_ARB_RR_EN for round-robin instead of dcache priority.
module mem_bus_arbiter #(
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = 4,
    parameter int XLEN     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       icache2arb_command,
    input  logic [XLEN-1:0]  icache2arb_addr,
    output logic [TAG_W-1:0] arb2icache_response,
    output logic [63:0]      arb2icache_data,
    output logic [TAG_W-1:0] arb2icache_tag,
    input  logic [1:0]       dcache2arb_command,
    input  logic [XLEN-1:0]  dcache2arb_addr,
    input  logic [63:0]      dcache2arb_data,
    output logic [TAG_W-1:0] arb2dcache_response,
    output logic [63:0]      arb2dcache_data,
    output logic [TAG_W-1:0] arb2dcache_tag,
    output logic [1:0]       arb2mem_command,
    output logic [XLEN-1:0]  arb2mem_addr,
    output logic [63:0]      arb2mem_data,
    input  logic [TAG_W-1:0] mem2arb_response,
    input  logic [63:0]      mem2arb_data,
    input  logic [TAG_W-1:0] mem2arb_tag,
    output logic             tag_err,
    output logic [1:0]       grant_debug
);
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic                i_req, d_req, gnt_i, gnt_d, accept, alloc;
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;  // 1 = dcache owns the tag
    logic                tag_err_q, tag_err_d;

    assign i_req  = (icache2arb_command == BUS_LOAD);
    assign d_req  = (dcache2arb_command == BUS_LOAD) || (dcache2arb_command == BUS_STORE);
    assign accept = (gnt_i || gnt_d) && (mem2arb_response != '0);
    assign alloc  = accept && (gnt_i || (dcache2arb_command == BUS_LOAD));

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;  // 1 = dcache was granted last

    always_comb begin
        gnt_d    = d_req && (!i_req || !last_d_q);
        gnt_i    = i_req && !gnt_d;
        last_d_d = accept ? gnt_d : last_d_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_d_q <= 1'b0;
        else       last_d_q <= last_d_d;
    end
`else
    always_comb begin
        gnt_d = d_req;
        gnt_i = i_req && !d_req;
    end
`endif

    always_comb begin
        arb2mem_command     = BUS_NONE;
        arb2mem_addr        = '0;
        arb2mem_data        = '0;
        arb2icache_response = '0;
        arb2dcache_response = '0;
        arb2icache_tag      = '0;
        arb2dcache_tag      = '0;
        arb2icache_data     = mem2arb_data;
        arb2dcache_data     = mem2arb_data;
        grant_debug         = {gnt_d, gnt_i};
        if (gnt_d) begin
            arb2mem_command     = dcache2arb_command;
            arb2mem_addr        = dcache2arb_addr;
            arb2mem_data        = dcache2arb_data;
            arb2dcache_response = mem2arb_response;
        end else if (gnt_i) begin
            arb2mem_command     = BUS_LOAD;
            arb2mem_addr        = icache2arb_addr;
            arb2icache_response = mem2arb_response;
        end
        if ((mem2arb_tag != '0) && valid_q[mem2arb_tag]) begin
            if (owner_q[mem2arb_tag]) arb2dcache_tag = mem2arb_tag;
            else                      arb2icache_tag = mem2arb_tag;
        end
        if (reset) begin
            arb2mem_command     = BUS_NONE;
            arb2mem_addr        = '0;
            arb2mem_data        = '0;
            arb2icache_response = '0;
            arb2dcache_response = '0;
            arb2icache_tag      = '0;
            arb2dcache_tag      = '0;
            arb2icache_data     = '0;
            arb2dcache_data     = '0;
            grant_debug         = 2'b00;
        end
    end

    // Retire first so a same-cycle allocate of that tag overrides the clear.
    always_comb begin
        valid_d   = valid_q;
        owner_d   = owner_q;
        tag_err_d = tag_err_q;
        if (mem2arb_tag != '0) begin
            if (valid_q[mem2arb_tag]) valid_d[mem2arb_tag] = 1'b0;
            else                      tag_err_d = 1'b1;
        end
        if (alloc) begin
            valid_d[mem2arb_response] = 1'b1;
            owner_d[mem2arb_response] = gnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            owner_q   <= '0;
            tag_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            owner_q   <= owner_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign tag_err = tag_err_q;
endmodule
